// File: rtl/dotprod_pkg.sv
// dotprod_pkg: shared definitions for the dot-product operand memory path.
// Holds the default geometry (element width, burst length, memory depth and
// address width), the writer state enum and the element_count width helper.
// No ports; imported by the writer, its interface and the address counter.
package dotprod_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int VECTOR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF        = 32;
  localparam int ADDR_WIDTH_DEF   = 5;

  // element_count must be able to hold VECTOR_WIDTH itself, not just VECTOR_WIDTH-1
  function automatic int count_width(input int vector_width);
    return $clog2(vector_width) + 1;
  endfunction

  localparam int COUNT_WIDTH_DEF = count_width(VECTOR_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

endpackage

// File: rtl/vec_mem_writer_if.sv
// vec_mem_writer_if: control, input stream and dual-memory write bus of the
// vector memory writer.
//   control : start_writing (in), writing_done, busy, element_count (out)
//   stream  : in_valid, in_data_a, in_data_b (in), in_ready (out)
//   mem1/2  : wr_en_memX, wr_addr_memX, wr_data_memX (out)
// Modport slave is the writer itself; master is the producer/controller side.
interface vec_mem_writer_if
  import dotprod_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) ();

  logic                   start_writing;
  logic                   writing_done;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] element_count;

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data_a;
  logic [DATA_WIDTH-1:0]  in_data_b;

  logic                   wr_en_mem1;
  logic                   wr_en_mem2;
  logic [ADDR_WIDTH-1:0]  wr_addr_mem1;
  logic [ADDR_WIDTH-1:0]  wr_addr_mem2;
  logic [DATA_WIDTH-1:0]  wr_data_mem1;
  logic [DATA_WIDTH-1:0]  wr_data_mem2;

  modport slave (
    input  start_writing, in_valid, in_data_a, in_data_b,
    output writing_done, busy, element_count, in_ready,
    output wr_en_mem1, wr_en_mem2, wr_addr_mem1, wr_addr_mem2,
    output wr_data_mem1, wr_data_mem2
  );

  modport master (
    output start_writing, in_valid, in_data_a, in_data_b,
    input  writing_done, busy, element_count, in_ready,
    input  wr_en_mem1, wr_en_mem2, wr_addr_mem1, wr_addr_mem2,
    input  wr_data_mem1, wr_data_mem2
  );

endinterface

// File: rtl/mod_addr_counter.sv
// mod_addr_counter: address counter that wraps modulo DEPTH (DEPTH need not
// be a power of two). Shared by the memory writer and reader.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   inc        : advance by one, DEPTH-1 wraps to 0
//   clr        : synchronous clear to 0, takes priority over inc
//   addr       : current address
module mod_addr_counter
  import dotprod_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= (addr == ADDR_MAX) ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/vec_mem_writer.sv
// vec_mem_writer: fills mem1 (vector A) and mem2 (vector B) of the
// dot-product datapath from a valid/ready stream of element pairs. Each
// start_writing in IDLE opens a burst of VECTOR_WIDTH pairs; every accepted
// pair produces one matched write to both memories one cycle later, and
// writing_done pulses the cycle after the last write strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : vec_mem_writer_if.slave (control, input stream, mem1/mem2 writes)
// Build option: MEM_WRITER_BASE_RESET_EN -- when defined, every accepted
// start_writing rewinds the write pointer to 0 so each burst lands at
// 0..VECTOR_WIDTH-1; otherwise the pointer persists across bursts and wraps
// modulo DEPTH.
module vec_mem_writer
  import dotprod_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input logic             clk,
  input logic             rst_n,
  vec_mem_writer_if.slave bus
);

  localparam int COUNT_WIDTH = count_width(VECTOR_WIDTH);

  writer_state_t          state;
  logic [COUNT_WIDTH-1:0] count;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [DATA_WIDTH-1:0]  data_a;
  logic [DATA_WIDTH-1:0]  data_b;

  logic start_accept;
  logic transfer;
  logic final_xfer;
  logic ptr_clr;

  // in_ready depends on state only, so transfer has no path through in_ready
  assign start_accept = (state == IDLE) && bus.start_writing;
  assign transfer     = (state == WRITE) && bus.in_valid;
  assign final_xfer   = transfer && (count == COUNT_WIDTH'(VECTOR_WIDTH - 1));

`ifdef MEM_WRITER_BASE_RESET_EN
  assign ptr_clr = start_accept;
`else
  assign ptr_clr = 1'b0;
`endif

  mod_addr_counter #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (transfer),
    .clr   (ptr_clr),
    .addr  (wr_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      data_a  <= '0;
      data_b  <= '0;
    end else begin
      // strobe is high only in the cycle after a transfer; address and data
      // hold their last values otherwise
      wr_en <= transfer;
      if (transfer) begin
        wr_addr <= wr_ptr;
        data_a  <= bus.in_data_a;
        data_b  <= bus.in_data_b;
        count   <= count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_accept) begin
            state <= WRITE;
            count <= '0;
          end
        end
        WRITE:   if (final_xfer) state <= LAST;
        LAST:    state <= DONE;   // final strobe visible during this cycle
        DONE:    state <= IDLE;   // start_writing on this edge is ignored
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state == WRITE);
  assign bus.busy          = (state != IDLE);
  assign bus.writing_done  = (state == DONE);
  assign bus.element_count = count;

  // both memories always see the same strobe and address
  assign bus.wr_en_mem1   = wr_en;
  assign bus.wr_en_mem2   = wr_en;
  assign bus.wr_addr_mem1 = wr_addr;
  assign bus.wr_addr_mem2 = wr_addr;
  assign bus.wr_data_mem1 = data_a;
  assign bus.wr_data_mem2 = data_b;

endmodule
